merger_tree_leaf_feeder: RTL and testbench

//  Producer side of the merger-tree leaf interface: feeds the 2*L leaf FIFO ports (data/empty/read) of the P8 merger tree.

---
 rtl/merger_tree_leaf_feeder.sv | 177 +++++++++++++++++
 tb/tb_merger_tree_leaf_feeder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merger_tree_leaf_feeder.sv
// Producer side of the merger-tree leaf interface: per-leaf show-ahead buffers filled by
// leaf-tagged refill beats, plus a round-robin credit requester (one outstanding beat per leaf).
module merger_tree_leaf_feeder #(
    parameter int L           = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BEAT_WORDS  = 8,
    parameter int LEAF_DEPTH  = 16,
    localparam int LW         = $clog2(2 * L)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_beat_valid,
    input  logic [LW-1:0]                    i_beat_leaf,
    input  logic [BEAT_WORDS*DATA_WIDTH-1:0] i_beat_data,
    output logic                             o_beat_ready,
    output logic                             o_req_valid,
    output logic [LW-1:0]                    o_req_leaf,
    input  logic                             i_req_ready,
    output logic [2*L*DATA_WIDTH-1:0]        o_fifo,
    output logic [2*L-1:0]                   o_fifo_empty,
    input  logic [2*L-1:0]                   i_fifo_read,
    output logic                             o_err
);

    localparam int NL = 2 * L;
    localparam int PW = $clog2(LEAF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LEAF_DEPTH);
    localparam logic [CW-1:0] BEAT_C  = CW'(BEAT_WORDS);

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_t;

    logic [DATA_WIDTH-1:0] r_mem    [NL][LEAF_DEPTH];
    logic [PW-1:0]         r_rd_ptr [NL];
    logic [PW-1:0]         r_wr_ptr [NL];
    logic [CW-1:0]         r_count  [NL];
    logic [NL-1:0]         r_pending;
    logic [LW-1:0]         r_rr;
    logic [LW-1:0]         r_hold_leaf;
    logic                  r_active;
    logic                  r_err;
    arb_state_t            r_state;
    arb_state_t            w_state_next;

    logic          w_beat_acc;
    logic          w_beat_ok;
    logic [NL-1:0] w_wr;
    logic [NL-1:0] w_pop;
    logic [NL-1:0] w_empty;
    logic [NL-1:0] w_elig;
    logic          w_found;
    logic [LW-1:0] w_pick;
    int            w_idx;
    logic          w_req_valid;
    logic [LW-1:0] w_req_leaf;
    logic          w_req_fire;

    // A beat is only stored if its leaf actually holds a credit; otherwise it is dropped.
    assign w_beat_acc = i_beat_valid && r_active;
    assign w_beat_ok  = w_beat_acc && r_pending[i_beat_leaf];
    assign w_req_fire = w_req_valid && i_req_ready;

    generate
        for (genvar k = 0; k < NL; k++) begin : g_leaf
            assign w_wr[k]    = w_beat_ok && (i_beat_leaf == LW'(k));
            assign w_empty[k] = (r_count[k] == '0);
            assign w_pop[k]   = i_fifo_read[k] && !w_empty[k];
            assign w_elig[k]  = !r_pending[k] && ((DEPTH_C - r_count[k]) >= BEAT_C);
            assign o_fifo[k*DATA_WIDTH +: DATA_WIDTH] = w_empty[k] ? '0 : r_mem[k][r_rd_ptr[k]];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rd_ptr[k]  <= '0;
                    r_wr_ptr[k]  <= '0;
                    r_count[k]   <= '0;
                    r_pending[k] <= 1'b0;
                end else begin
                    if (w_pop[k]) begin
                        r_rd_ptr[k] <= r_rd_ptr[k] + 1'b1;
                    end
                    if (w_wr[k]) begin
                        r_wr_ptr[k] <= r_wr_ptr[k] + PW'(BEAT_WORDS);
                    end
                    r_count[k] <= r_count[k] + (w_wr[k] ? BEAT_C : '0) - (w_pop[k] ? CW'(1) : '0);
                    if (w_wr[k]) begin
                        r_pending[k] <= 1'b0;
                    end else if (w_req_fire && (w_req_leaf == LW'(k))) begin
                        r_pending[k] <= 1'b1;
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (w_wr[k]) begin
                    for (int j = 0; j < BEAT_WORDS; j++) begin
                        r_mem[k][r_wr_ptr[k] + PW'(j)] <= i_beat_data[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    endgenerate

    // Round-robin search for the first eligible leaf at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 0; i < NL; i++) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= NL) begin
                w_idx = w_idx - NL;
            end
            if (!w_found && w_elig[LW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = LW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        w_req_leaf   = '0;
        case (r_state)
            ARB_IDLE: begin
                if (r_active && w_found) begin
                    w_req_valid = 1'b1;
                    w_req_leaf  = w_pick;
                    if (!i_req_ready) begin
                        w_state_next = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                w_req_valid = 1'b1;
                w_req_leaf  = r_hold_leaf;
                if (i_req_ready) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // A held request keeps its leaf: that leaf cannot lose eligibility while it has no credit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ARB_IDLE;
            r_hold_leaf <= '0;
            r_rr        <= '0;
            r_active    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_active <= 1'b1;
            if ((r_state == ARB_IDLE) && (w_state_next == ARB_HOLD)) begin
                r_hold_leaf <= w_req_leaf;
            end
            if (w_req_fire) begin
                r_rr <= (w_req_leaf == LW'(NL - 1)) ? '0 : w_req_leaf + 1'b1;
            end
            if (w_beat_acc && !r_pending[i_beat_leaf]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_beat_ready = r_active;
    assign o_req_valid  = w_req_valid;
    assign o_req_leaf   = w_req_leaf;
    assign o_fifo_empty = w_empty;
    assign o_err        = r_err;

endmodule

// File: tb/tb_merger_tree_leaf_feeder.sv
// Self-checking bench for merger_tree_leaf_feeder: directed scenarios plus randomized traffic
// compared against a queue-based model of the leaf buffers and credit requester.
module tb_merger_tree_leaf_feeder;

    localparam int NL = 64;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int DEPTH = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 beat_valid;
    logic [5:0]           beat_leaf;
    logic [BW*DW-1:0]     beat_data;
    logic                 beat_ready;
    logic                 req_valid;
    logic [5:0]           req_leaf;
    logic                 req_ready;
    logic [NL*DW-1:0]     fifo;
    logic [NL-1:0]        fifo_empty;
    logic [NL-1:0]        fifo_read;
    logic                 err;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of words per leaf, credit flags, RR pointer, held request.
    logic [DW-1:0] mq [NL][$];
    bit            mpend [NL];
    int            mrr;
    bit            merr;
    bit            mactive;
    bit            mhold;
    int            mheld;

    merger_tree_leaf_feeder #(
        .L(32), .DATA_WIDTH(DW), .BEAT_WORDS(BW), .LEAF_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_beat_valid(beat_valid),
        .i_beat_leaf(beat_leaf),
        .i_beat_data(beat_data),
        .o_beat_ready(beat_ready),
        .o_req_valid(req_valid),
        .o_req_leaf(req_leaf),
        .i_req_ready(req_ready),
        .o_fifo(fifo),
        .o_fifo_empty(fifo_empty),
        .i_fifo_read(fifo_read),
        .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int k = 0; k < NL; k++) begin
            mq[k].delete();
            mpend[k] = 1'b0;
        end
        mrr = 0; merr = 1'b0; mactive = 1'b0; mhold = 1'b0; mheld = 0;
    endfunction

    function automatic void model_req(output bit v, output int lf);
        v = 1'b0;
        lf = 0;
        if (!mactive) return;
        if (mhold) begin
            v = 1'b1; lf = mheld;
            return;
        end
        for (int i = 0; i < NL; i++) begin
            int k;
            k = (mrr + i) % NL;
            if (!mpend[k] && (DEPTH - mq[k].size()) >= BW) begin
                v = 1'b1; lf = k;
                return;
            end
        end
    endfunction

    // Advance one clock, applying the inputs present at the edge to the model.
    task automatic tick();
        bit ev;
        int el;
        model_req(ev, el);
        @(posedge clk);
        if (rst_n && mactive) begin
            for (int k = 0; k < NL; k++) begin
                if (fifo_read[k] && mq[k].size() > 0) void'(mq[k].pop_front());
            end
            if (beat_valid) begin
                if (mpend[beat_leaf]) begin
                    for (int j = 0; j < BW; j++) mq[beat_leaf].push_back(beat_data[j*DW +: DW]);
                    mpend[beat_leaf] = 1'b0;
                end else begin
                    merr = 1'b1;
                end
            end
            if (ev && req_ready) begin
                mpend[el] = 1'b1; mrr = (el + 1) % NL; mhold = 1'b0;
            end else if (ev) begin
                mhold = 1'b1; mheld = el;
            end
        end
        mactive = rst_n;
        @(negedge clk);
    endtask

    task automatic send_beat(input int leaf, input logic [DW-1:0] base);
        beat_valid = 1'b1;
        beat_leaf  = 6'(leaf);
        for (int j = 0; j < BW; j++) beat_data[j*DW +: DW] = base + DW'(j);
        tick();
        beat_valid = 1'b0;
    endtask

    task automatic pop_leaf(input int leaf);
        fifo_read = '0;
        fifo_read[leaf] = 1'b1;
        tick();
        fifo_read = '0;
    endtask

    task automatic grant_leaf(input int leaf, output bit ok);
        ok = 1'b0;
        req_ready = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (req_valid && req_leaf == 6'(leaf)) ok = 1'b1;
            tick();
        end
        req_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        beat_valid = 1'b0; fifo_read = '0; req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_empty !== '1) begin
            errors++; $display("[TB] FAIL reset_empty got %h want all ones", fifo_empty);
        end
        checks++;
        if (req_valid !== 1'b0 || err !== 1'b0 || beat_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got req_valid=%b err=%b beat_ready=%b want 0 0 0", req_valid, err, beat_ready);
        end
        checks++;
        if (fifo !== '0) begin
            errors++; $display("[TB] FAIL reset_fifo got nonzero head data want 0");
        end
        model_clear();
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (beat_ready !== 1'b0 || req_leaf !== 6'd0) begin
            errors++; $display("[TB] FAIL reset_release got beat_ready=%b req_leaf=%0d want 0 0", beat_ready, req_leaf);
        end
    endtask

    task automatic test_request_sweep();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL sweep_pre got req_valid=%b want 0", req_valid);
        end
        tick();
        checks++;
        if (beat_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL sweep_ready got %b want 1", beat_ready);
        end
        req_ready = 1'b1;
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (req_valid !== 1'b1 || req_leaf !== 6'(i)) begin
                errors++; $display("[TB] FAIL sweep_req got valid=%b leaf=%0d want 1 %0d", req_valid, req_leaf, i);
            end
            tick();
        end
        checks++;
        if (req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL sweep_done got req_valid=%b want 0", req_valid);
        end
        req_ready = 1'b0;
    endtask

    task automatic test_show_ahead();
        send_beat(5, 32'h10);
        checks++;
        if (fifo_empty[5] !== 1'b0 || fifo[5*DW +: DW] !== 32'h10) begin
            errors++; $display("[TB] FAIL leaf5_first got empty=%b head=%h want 0 10", fifo_empty[5], fifo[5*DW +: DW]);
        end
        for (int i = 0; i < BW; i++) begin
            checks++;
            if (fifo[5*DW +: DW] !== 32'h10 + DW'(i)) begin
                errors++; $display("[TB] FAIL leaf5_order got %h want %h", fifo[5*DW +: DW], 32'h10 + i);
            end
            pop_leaf(5);
        end
        checks++;
        if (fifo_empty[5] !== 1'b1) begin
            errors++; $display("[TB] FAIL leaf5_drained got empty=%b want 1", fifo_empty[5]);
        end
    endtask

    task automatic test_refill_credit();
        bit ok;
        send_beat(3, 32'h20);
        grant_leaf(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("[TB] FAIL leaf3_grant got timeout want request for leaf 3");
        end
        send_beat(3, 32'h28);
        checks++;
        if (req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL leaf3_full got req_valid=%b want 0", req_valid);
        end
        for (int i = 0; i < BW; i++) begin
            checks++;
            if (fifo[3*DW +: DW] !== 32'h20 + DW'(i)) begin
                errors++; $display("[TB] FAIL leaf3_order got %h want %h", fifo[3*DW +: DW], 32'h20 + i);
            end
            pop_leaf(3);
            checks++;
            if (req_valid !== (i == BW - 1) || (i == BW - 1 && req_leaf !== 6'd3)) begin
                errors++;
                $display("[TB] FAIL leaf3_credit after pop %0d got valid=%b leaf=%0d want %b 3", i + 1, req_valid, req_leaf, i == BW - 1);
            end
        end
    endtask

    task automatic test_drop_error();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("[TB] FAIL err_pre got %b want 0", err);
        end
        send_beat(7, 32'h70);
        for (int i = 0; i < BW; i++) pop_leaf(7);
        send_beat(7, 32'hDEAD0000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (err !== 1'b1 || fifo_empty[7] !== 1'b1) begin
                errors++; $display("[TB] FAIL drop_leaf7 got err=%b empty=%b want 1 1", err, fifo_empty[7]);
            end
            tick();
        end
    endtask

    task automatic test_wrap_concurrent();
        bit ok;
        logic [DW-1:0] expq [$];
        send_beat(2, 32'h40);
        grant_leaf(2, ok);
        checks++;
        if (!ok) begin
            errors++; $display("[TB] FAIL leaf2_grant1 got timeout want request for leaf 2");
        end
        for (int i = 0; i < BW; i++) pop_leaf(2);
        send_beat(2, 32'h50);
        grant_leaf(2, ok);
        checks++;
        if (!ok) begin
            errors++; $display("[TB] FAIL leaf2_grant2 got timeout want request for leaf 2");
        end
        checks++;
        if (fifo[2*DW +: DW] !== 32'h50) begin
            errors++; $display("[TB] FAIL leaf2_head got %h want 50", fifo[2*DW +: DW]);
        end
        fifo_read[2] = 1'b1;
        send_beat(2, 32'h60);
        fifo_read = '0;
        checks++;
        if (fifo_empty[2] !== 1'b0 || req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL leaf2_concurrent got empty=%b req_valid=%b want 0 0", fifo_empty[2], req_valid);
        end
        for (int i = 1; i < BW; i++) expq.push_back(32'h50 + DW'(i));
        for (int i = 0; i < BW; i++) expq.push_back(32'h60 + DW'(i));
        foreach (expq[i]) begin
            checks++;
            if (fifo_empty[2] !== 1'b0 || fifo[2*DW +: DW] !== expq[i]) begin
                errors++; $display("[TB] FAIL leaf2_wrap idx %0d got %h want %h", i, fifo[2*DW +: DW], expq[i]);
            end
            pop_leaf(2);
        end
        checks++;
        if (fifo_empty[2] !== 1'b1) begin
            errors++; $display("[TB] FAIL leaf2_drained got empty=%b want 1", fifo_empty[2]);
        end
    endtask

    task automatic test_random(input int cycles);
        bit ev;
        int el;
        int bad;
        logic [NL-1:0] exp_empty;
        logic [DW-1:0] expv;
        logic [DW-1:0] badv;
        for (int c = 0; c < cycles; c++) begin
            model_req(ev, el);
            for (int k = 0; k < NL; k++) exp_empty[k] = (mq[k].size() == 0);
            checks++;
            if (beat_ready !== mactive || err !== merr) begin
                errors++; $display("[TB] FAIL rand_ctrl cyc %0d got ready=%b err=%b want %b %b", c, beat_ready, err, mactive, merr);
            end
            checks++;
            if (req_valid !== ev || (ev && req_leaf !== 6'(el))) begin
                errors++; $display("[TB] FAIL rand_req cyc %0d got valid=%b leaf=%0d want %b %0d", c, req_valid, req_leaf, ev, el);
            end
            checks++;
            if (fifo_empty !== exp_empty) begin
                errors++; $display("[TB] FAIL rand_empty cyc %0d got %h want %h", c, fifo_empty, exp_empty);
            end
            bad = -1;
            badv = '0;
            for (int k = 0; k < NL; k++) begin
                expv = (mq[k].size() > 0) ? mq[k][0] : '0;
                if (bad < 0 && fifo[k*DW +: DW] !== expv) begin
                    bad = k; badv = expv;
                end
            end
            checks++;
            if (bad >= 0) begin
                errors++; $display("[TB] FAIL rand_head cyc %0d leaf %0d got %h want %h", c, bad, fifo[bad*DW +: DW], badv);
            end
            req_ready = 1'($urandom_range(0, 1));
            fifo_read = {$urandom, $urandom} & {$urandom, $urandom};
            beat_valid = 1'b0;
            el = $urandom_range(0, 99);
            if (el < 45) begin
                int st;
                st = $urandom_range(0, NL - 1);
                for (int i = 0; i < NL && !beat_valid; i++) begin
                    if (mpend[(st + i) % NL]) begin
                        beat_valid = 1'b1; beat_leaf = 6'((st + i) % NL);
                    end
                end
            end else if (el < 47) begin
                beat_valid = 1'b1; beat_leaf = 6'($urandom_range(0, NL - 1));
            end
            for (int j = 0; j < BW; j++) beat_data[j*DW +: DW] = $urandom;
            tick();
        end
        beat_valid = 1'b0; fifo_read = '0; req_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; beat_valid = 1'b0; beat_leaf = '0; beat_data = '0;
        req_ready = 1'b0; fifo_read = '0;
        model_clear();
        test_reset();
        test_request_sweep();
        test_show_ahead();
        test_refill_credit();
        test_drop_error();
        test_wrap_concurrent();
        test_reset();
        test_random(1500);
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
